routing_matrix_xf: RTL and testbench

ROUTING_MATRIX_XF -- requirements
Module: routing_matrix_xf

---
 rtl/routing_matrix_xf.sv | 252 +++++++++++++++++++++++++
 tb/tb_routing_matrix_xf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/routing_matrix_xf.sv
// Frame-sequenced NUM_IN x NUM_OUT routing matrix with per-destination Q1.7 gain and saturation.
// Optional per-destination crossfade on source change is enabled by defining ROUTING_XFADE_EN.
module routing_matrix_xf #(
    parameter int BITSIZE    = 16,
    parameter int NUM_IN     = 16,
    parameter int NUM_OUT    = 16,
    parameter int XFADE_BITS = 6,
    localparam int SELBITS   = $clog2(NUM_IN) + 1,
    localparam int OUTBITS   = $clog2(NUM_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
    input  logic [NUM_IN*BITSIZE-1:0]   in_flat,
    input  logic                        cfg_wr,
    input  logic [OUTBITS-1:0]          cfg_addr,
    input  logic [SELBITS-1:0]          cfg_sel,
    input  logic [7:0]                  cfg_gain,
    output logic [NUM_OUT*BITSIZE-1:0]  out_flat,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int CW = $clog2(NUM_OUT + 2);
    localparam int PW = BITSIZE + 10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;
    logic signed [BITSIZE-1:0] snap_q [NUM_IN];
    logic signed [BITSIZE-1:0] snap_d [NUM_IN];
    logic signed [BITSIZE-1:0] out_q  [NUM_OUT];
    logic signed [BITSIZE-1:0] out_d  [NUM_OUT];
    logic [SELBITS-1:0]        sel_q  [NUM_OUT];
    logic [SELBITS-1:0]        sel_d  [NUM_OUT];
    logic [SELBITS-1:0]        psel_q [NUM_OUT];
    logic [SELBITS-1:0]        psel_d [NUM_OUT];
    logic [7:0]                gain_q [NUM_OUT];
    logic [7:0]                gain_d [NUM_OUT];
    logic [7:0]                pgain_q[NUM_OUT];
    logic [7:0]                pgain_d[NUM_OUT];
    logic                      p_vld_q, p_vld_d;
    logic [CW-1:0]             p_idx_q, p_idx_d;
    logic signed [BITSIZE-1:0] p_val_q, p_val_d;

`ifdef ROUTING_XFADE_EN
    localparam int MW = BITSIZE + XFADE_BITS + 2;
    localparam logic [XFADE_BITS:0] XF_N = {1'b1, {XFADE_BITS{1'b0}}};

    logic [SELBITS-1:0]        prev_q [NUM_OUT];
    logic [SELBITS-1:0]        prev_d [NUM_OUT];
    logic [XFADE_BITS:0]       k_q    [NUM_OUT];
    logic [XFADE_BITS:0]       k_d    [NUM_OUT];
    logic                      xf_q   [NUM_OUT];
    logic                      xf_d   [NUM_OUT];
    logic [SELBITS-1:0]        cur_prev;
    logic [XFADE_BITS:0]       cur_k;
    logic                      cur_xf;
    logic signed [MW-1:0]      old_w, new_w, kw, kinv, mix;
`endif

    logic [SELBITS-1:0]        cur_sel;
    logic [7:0]                cur_gain;
    logic signed [BITSIZE-1:0] src;
    logic signed [PW-1:0]      gw, prod, shp;
    logic signed [BITSIZE-1:0] sat_val;

    // Mute (sel >= NUM_IN) falls out naturally: no source index matches.
    function automatic logic signed [BITSIZE-1:0] pick(
        input logic [SELBITS-1:0]        s,
        input logic signed [BITSIZE-1:0] snap [NUM_IN]
    );
        logic signed [BITSIZE-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (int'(s) == i) r = snap[i];
        return r;
    endfunction

    always_comb begin : datapath
        cur_sel  = '0;
        cur_gain = '0;
`ifdef ROUTING_XFADE_EN
        cur_prev = '0;
        cur_k    = '0;
        cur_xf   = 1'b0;
`endif
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(cnt_q) == i) begin
                cur_sel  = sel_q[i];
                cur_gain = gain_q[i];
`ifdef ROUTING_XFADE_EN
                cur_prev = prev_q[i];
                cur_k    = k_q[i];
                cur_xf   = xf_q[i];
`endif
            end
        end
        src = pick(cur_sel, snap_q);
`ifdef ROUTING_XFADE_EN
        // Mix is a convex combination, so it always fits back into BITSIZE.
        old_w = MW'(pick(cur_prev, snap_q));
        new_w = MW'(src);
        kw    = MW'(cur_k);
        kinv  = MW'(XF_N - cur_k);
        mix   = old_w * kinv + new_w * kw;
        if (cur_xf) src = BITSIZE'(mix >>> XFADE_BITS);
`endif
        gw      = PW'({1'b0, cur_gain});
        prod    = PW'(src) * gw;
        shp     = prod >>> 7;
        sat_val = shp[BITSIZE-1:0];
        if (!shp[PW-1] && (|shp[PW-2:BITSIZE-1]))
            sat_val = {1'b0, {(BITSIZE-1){1'b1}}};
        else if (shp[PW-1] && !(&shp[PW-2:BITSIZE-1]))
            sat_val = {1'b1, {(BITSIZE-1){1'b0}}};
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        p_vld_d = 1'b0;
        p_idx_d = p_idx_q;
        p_val_d = p_val_q;
        for (int i = 0; i < NUM_IN; i++) snap_d[i] = snap_q[i];
        for (int i = 0; i < NUM_OUT; i++) begin
            out_d[i]   = out_q[i];
            sel_d[i]   = sel_q[i];
            gain_d[i]  = gain_q[i];
            psel_d[i]  = psel_q[i];
            pgain_d[i] = pgain_q[i];
`ifdef ROUTING_XFADE_EN
            prev_d[i]  = prev_q[i];
            k_d[i]     = k_q[i];
            xf_d[i]    = xf_q[i];
`endif
            // Out-of-range cfg_addr never matches a destination index.
            if (cfg_wr && int'(cfg_addr) == i) begin
                psel_d[i]  = cfg_sel;
                pgain_d[i] = cfg_gain;
            end
        end

        case (state_q)
            S_RUN: begin
                if (sample_tick) ovr_d = 1'b1;
                if (int'(cnt_q) < NUM_OUT) begin
                    p_vld_d = 1'b1;
                    p_idx_d = cnt_q;
                    p_val_d = sat_val;
                end
                for (int i = 0; i < NUM_OUT; i++)
                    if (p_vld_q && int'(p_idx_q) == i) out_d[i] = p_val_q;
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_q) == NUM_OUT + 1) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (sample_tick) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_IN; i++)
                        snap_d[i] = in_flat[i*BITSIZE +: BITSIZE];
                    for (int i = 0; i < NUM_OUT; i++) begin
                        sel_d[i]  = psel_d[i];
                        gain_d[i] = pgain_d[i];
`ifdef ROUTING_XFADE_EN
                        if (psel_d[i] != sel_q[i]) begin
                            prev_d[i] = sel_q[i];
                            k_d[i]    = {{XFADE_BITS{1'b0}}, 1'b1};
                            xf_d[i]   = 1'b1;
                        end else if (xf_q[i]) begin
                            if (k_q[i] == XF_N) xf_d[i] = 1'b0;
                            else                k_d[i]  = k_q[i] + 1'b1;
                        end
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            p_vld_q <= 1'b0;
            p_idx_q <= '0;
            p_val_q <= '0;
            for (int i = 0; i < NUM_IN; i++) snap_q[i] <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                out_q[i]   <= '0;
                sel_q[i]   <= '0;
                psel_q[i]  <= '0;
                gain_q[i]  <= 8'h80;
                pgain_q[i] <= 8'h80;
`ifdef ROUTING_XFADE_EN
                prev_q[i]  <= '0;
                k_q[i]     <= '0;
                xf_q[i]    <= 1'b0;
`endif
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            p_vld_q <= p_vld_d;
            p_idx_q <= p_idx_d;
            p_val_q <= p_val_d;
            for (int i = 0; i < NUM_IN; i++) snap_q[i] <= snap_d[i];
            for (int i = 0; i < NUM_OUT; i++) begin
                out_q[i]   <= out_d[i];
                sel_q[i]   <= sel_d[i];
                psel_q[i]  <= psel_d[i];
                gain_q[i]  <= gain_d[i];
                pgain_q[i] <= pgain_d[i];
`ifdef ROUTING_XFADE_EN
                prev_q[i]  <= prev_d[i];
                k_q[i]     <= k_d[i];
                xf_q[i]    <= xf_d[i];
`endif
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_flat[g*BITSIZE +: BITSIZE] = out_q[g];
    end

    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_routing_matrix_xf.sv
// Directed self-checking bench for routing_matrix_xf; crossfade expectations follow ROUTING_XFADE_EN.
module tb_routing_matrix_xf;

    localparam int BS = 16;
    localparam int NI = 16;
    localparam int NO = 12;
    localparam int XB = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_tick = 1'b0;
    logic [NI*BS-1:0]  in_flat = '0;
    logic              cfg_wr = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic [4:0]        cfg_sel = '0;
    logic [7:0]        cfg_gain = '0;
    logic [NO*BS-1:0]  out_flat;
    logic              out_valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [15:0] exp_o [NO];

    routing_matrix_xf #(.BITSIZE(BS), .NUM_IN(NI), .NUM_OUT(NO), .XFADE_BITS(XB)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .in_flat(in_flat),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_gain(cfg_gain),
        .out_flat(out_flat), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int i, input logic [15:0] v);
        in_flat[i*BS +: BS] = v;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] a, input logic [4:0] s, input logic [7:0] g);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = a; cfg_sel = s; cfg_gain = g;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic run_frame(input bit wr, input logic [3:0] a, input logic [4:0] s, input logic [7:0] g);
        int lat;
        @(negedge clk);
        sample_tick = 1'b1;
        if (wr) begin cfg_wr = 1'b1; cfg_addr = a; cfg_sel = s; cfg_gain = g; end
        @(negedge clk);
        sample_tick = 1'b0; cfg_wr = 1'b0;
        chk("busy_run", {31'd0, busy}, 32'd1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NO + 2);
        chk("busy_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NO; i++)
            chk($sformatf("%s_o%0d", tag, i), {16'd0, out_flat[i*BS +: BS]}, {16'd0, exp_o[i]});
    endtask

    task automatic fill_exp(input logic [15:0] v);
        for (int i = 0; i < NO; i++) exp_o[i] = v;
    endtask

    initial begin
        int base;
        int nf;
        logic [15:0] xf_seq [5];

        for (int i = 0; i < NI; i++) set_in(i, 16'(i * 16'h0111 + 16'h0100));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out", {31'd0, out_flat == '0}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);

        // Default routing: every destination follows source 0 at unity gain.
        set_in(0, 16'h1234);
        base = pulses;
        run_frame(0, '0, '0, '0);
        @(negedge clk);
        chk("one_pulse", pulses - base, 1);
        fill_exp(16'h1234);
        check_all("unity");

        // Saturation; in0 tracks in2 so any crossfade mix is exact.
        cfg(4'd3, 5'd2, 8'hFF);
        set_in(0, 16'h7000); set_in(2, 16'h7000);
        run_frame(0, '0, '0, '0);
        fill_exp(16'h7000); exp_o[3] = 16'h7FFF;
        check_all("satpos");
        set_in(0, 16'h9000); set_in(2, 16'h9000);
        run_frame(0, '0, '0, '0);
        fill_exp(16'h9000); exp_o[3] = 16'h8000;
        check_all("satneg");

        // Last write wins, and a write coincident with the tick joins that frame.
        do_reset();
        set_in(0, 16'h4000);
        cfg(4'd4, 5'd0, 8'h20);
        cfg(4'd4, 5'd0, 8'h40);
        run_frame(1, 4'd2, 5'd0, 8'hC0);
        fill_exp(16'h4000); exp_o[2] = 16'h6000; exp_o[4] = 16'h2000;
        check_all("gain");

        // Mute source, then an out-of-range address that must change nothing.
        cfg(4'd5, 5'd16, 8'h80);
        set_in(0, 16'h2222);
`ifdef ROUTING_XFADE_EN
        nf = 4;
`else
        nf = 1;
`endif
        for (int f = 0; f < nf; f++) run_frame(0, '0, '0, '0);
        fill_exp(16'h2222); exp_o[2] = 16'h3333; exp_o[4] = 16'h1111; exp_o[5] = 16'h0000;
        check_all("mute");
        cfg(4'd12, 5'd1, 8'h00);
        run_frame(0, '0, '0, '0);
        check_all("badaddr");

        // Second tick three cycles into a frame.
        do_reset();
        set_in(0, 16'h1111);
        base = pulses;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (30) @(negedge clk);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_pulses", pulses - base, 1);
        chk("ovr_out0", {16'd0, out_flat[0 +: BS]}, 32'h1111);

        // Source switch on dest 0: ramp when crossfading, hard step otherwise.
        do_reset();
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        set_in(0, 16'h4000); set_in(1, 16'h0000);
        run_frame(0, '0, '0, '0);
        chk("xf_pre", {16'd0, out_flat[0 +: BS]}, 32'h4000);
        cfg(4'd0, 5'd1, 8'h80);
`ifdef ROUTING_XFADE_EN
        xf_seq[0] = 16'h3000; xf_seq[1] = 16'h2000; xf_seq[2] = 16'h1000;
        xf_seq[3] = 16'h0000; xf_seq[4] = 16'h0000;
        nf = 5;
`else
        xf_seq[0] = 16'h0000; xf_seq[1] = 16'h0000; xf_seq[2] = 16'h0000;
        xf_seq[3] = 16'h0000; xf_seq[4] = 16'h0000;
        nf = 2;
`endif
        for (int f = 0; f < nf; f++) begin
            run_frame(0, '0, '0, '0);
            chk($sformatf("xf_f%0d", f), {16'd0, out_flat[0 +: BS]}, {16'd0, xf_seq[f]});
            chk($sformatf("xf_o1_f%0d", f), {16'd0, out_flat[BS +: BS]}, 32'h4000);
        end

        // Reset four cycles into a frame aborts it.
        do_reset();
        set_in(0, 16'h5555);
        run_frame(0, '0, '0, '0);
        chk("pre_abort", {16'd0, out_flat[3*BS +: BS]}, 32'h5555);
        @(negedge clk);
        base = pulses;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_out", {31'd0, out_flat == '0}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_nopulse", pulses - base, 0);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
